// File: rtl/ctrl_pkg.sv
// Shared types for the pipelined control unit: opcode map, alu_op encodings,
// the per-stage control bundle and the bubble constant.
package ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_LDI   = 4'h2,
        OP_STORE = 4'h3,
        OP_MOVE  = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_NOT   = 4'h8,
        OP_NEG   = 4'h9,
        OP_SL    = 4'hA,
        OP_SR    = 4'hB,
        OP_ADD   = 4'hC,
        OP_SUB   = 4'hD,
        OP_MUL   = 4'hE,
        OP_J     = 4'hF
    } opcode_e;

    localparam logic [1:0] ALU_NOP  = 2'b11;
    localparam logic [1:0] ALU_PASS = 2'b10;
    localparam logic [1:0] ALU_USE  = 2'b01;
    localparam logic [1:0] ALU_JMP  = 2'b00;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       r;
        logic       i;
        logic       j;
        logic       mem_wr;
        logic       mem_rd;
        logic       we;
        logic       sel_mem;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{ALU_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/ctrl_dec.sv
// Combinational opcode decoder: produces the control bundle and which source
// operands the instruction reads. Opcodes with bits above [3:0] set are NOPs.
module ctrl_dec
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 4
) (
    input  logic [OP_W-1:0] op,
    output ctrl_t           ctrl,
    output logic            uses_rs,
    output logic            uses_rt
);

    logic       hi_nz;
    logic [3:0] op4;

    generate
        if (OP_W > 4) begin : g_wide
            assign hi_nz = |op[OP_W-1:4];
        end else begin : g_narrow
            assign hi_nz = 1'b0;
        end
    endgenerate

    assign op4 = op[3:0];

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        if (!hi_nz) begin
            case (op4)
                OP_LOAD: begin
                    ctrl.alu_op = ALU_PASS; ctrl.i = 1'b1; ctrl.mem_rd = 1'b1;
                    ctrl.we = 1'b1; ctrl.sel_mem = 1'b1; uses_rs = 1'b1;
                end
                OP_LDI: begin
                    ctrl.alu_op = ALU_PASS; ctrl.i = 1'b1; ctrl.we = 1'b1;
                end
                OP_STORE: begin
                    ctrl.alu_op = ALU_PASS; ctrl.i = 1'b1; ctrl.mem_wr = 1'b1;
                    uses_rs = 1'b1; uses_rt = 1'b1;
                end
                OP_MOVE: begin
                    ctrl.alu_op = ALU_PASS; ctrl.r = 1'b1; ctrl.we = 1'b1; uses_rs = 1'b1;
                end
                OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MUL: begin
                    ctrl.alu_op = ALU_USE; ctrl.r = 1'b1; ctrl.we = 1'b1;
                    uses_rs = 1'b1; uses_rt = 1'b1;
                end
                OP_NOT, OP_NEG, OP_SL, OP_SR: begin
                    ctrl.alu_op = ALU_USE; ctrl.r = 1'b1; ctrl.we = 1'b1; uses_rs = 1'b1;
                end
                OP_J: begin
                    ctrl.alu_op = ALU_JMP; ctrl.j = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// hazard stall/flush. Define CTRL_FWD_EN to enable forwarding and fwd_a/fwd_b.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 4,
    parameter int unsigned RA_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_i,
    input  logic [OP_W-1:0] op_i,
    input  logic [RA_W-1:0] rs_i,
    input  logic [RA_W-1:0] rt_i,
    input  logic [RA_W-1:0] rd_i,
    output logic            stall_o,
    output logic            flush_o,
    output logic [1:0]      ex_alu_op,
    output logic [OP_W-1:0] ex_alu_fn,
    output logic            ex_r,
    output logic            ex_i,
    output logic            ex_j,
    output logic            mem_wr,
    output logic            mem_rd,
    output logic            wb_we,
    output logic            wb_sel_mem,
    output logic [RA_W-1:0] wb_rd
`ifdef CTRL_FWD_EN
    ,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
`endif
);

    ctrl_t           dec_c;
    logic            dec_rs, dec_rt;

    ctrl_t           ex_c;
    logic [RA_W-1:0] ex_dst;
    logic            mem_we, mem_sel;
    logic [RA_W-1:0] mem_dst;
    logic            ex_hit, hazard;

    ctrl_dec #(.OP_W(OP_W)) u_dec (
        .op      (op_i),
        .ctrl    (dec_c),
        .uses_rs (dec_rs),
        .uses_rt (dec_rt)
    );

    assign ex_hit = ex_c.we && ((dec_rs && rs_i == ex_dst) || (dec_rt && rt_i == ex_dst));

`ifdef CTRL_FWD_EN
    logic            ex_use_rs, ex_use_rt;
    logic [RA_W-1:0] ex_rs, ex_rt;

    assign hazard = ex_hit && ex_c.mem_rd;

    // A LOAD in MEM has no result yet, so only non-load writers forward from EX/MEM.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        if (ex_use_rs && mem_we && !mem_rd && mem_dst == ex_rs) fwd_a = 2'b01;
        else if (ex_use_rs && wb_we && wb_rd == ex_rs)          fwd_a = 2'b10;
        if (ex_use_rt && mem_we && !mem_rd && mem_dst == ex_rt) fwd_b = 2'b01;
        else if (ex_use_rt && wb_we && wb_rd == ex_rt)          fwd_b = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_use_rs <= 1'b0;
            ex_use_rt <= 1'b0;
            ex_rs     <= '0;
            ex_rt     <= '0;
        end else if (!hold_i) begin
            ex_use_rs <= dec_rs && !hazard;
            ex_use_rt <= dec_rt && !hazard;
            ex_rs     <= hazard ? '0 : rs_i;
            ex_rt     <= hazard ? '0 : rt_i;
        end
    end
`else
    logic mem_hit;
    assign mem_hit = mem_we && ((dec_rs && rs_i == mem_dst) || (dec_rt && rt_i == mem_dst));
    assign hazard  = ex_hit || mem_hit;
`endif

    assign stall_o = hold_i || hazard;
    assign flush_o = !hold_i && !hazard && dec_c.j;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_c       <= CTRL_BUBBLE;
            ex_alu_fn  <= '0;
            ex_dst     <= '0;
            mem_wr     <= 1'b0;
            mem_rd     <= 1'b0;
            mem_we     <= 1'b0;
            mem_sel    <= 1'b0;
            mem_dst    <= '0;
            wb_we      <= 1'b0;
            wb_sel_mem <= 1'b0;
            wb_rd      <= '0;
        end else if (!hold_i) begin
            if (hazard) begin
                ex_c      <= CTRL_BUBBLE;
                ex_alu_fn <= '0;
                ex_dst    <= '0;
            end else begin
                ex_c      <= dec_c;
                ex_alu_fn <= op_i;
                ex_dst    <= dec_c.we ? rd_i : '0;
            end
            mem_wr     <= ex_c.mem_wr;
            mem_rd     <= ex_c.mem_rd;
            mem_we     <= ex_c.we;
            mem_sel    <= ex_c.sel_mem;
            mem_dst    <= ex_dst;
            wb_we      <= mem_we;
            wb_sel_mem <= mem_sel;
            wb_rd      <= mem_dst;
        end
    end

    assign ex_alu_op = ex_c.alu_op;
    assign ex_r      = ex_c.r;
    assign ex_i      = ex_c.i;
    assign ex_j      = ex_c.j;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe; expectations follow CTRL_FWD_EN.
module tb_ctrl_pipe;

    logic       clk, rst, hold_i;
    logic [3:0] op_i, rs_i, rt_i, rd_i;
    logic       stall_o, flush_o;
    logic [1:0] ex_alu_op;
    logic [3:0] ex_alu_fn;
    logic       ex_r, ex_i, ex_j, mem_wr, mem_rd, wb_we, wb_sel_mem;
    logic [3:0] wb_rd;
`ifdef CTRL_FWD_EN
    logic [1:0] fwd_a, fwd_b;
    localparam int RAW_ST = 0;
    localparam int LU_ST  = 1;
`else
    localparam int RAW_ST = 2;
    localparam int LU_ST  = 2;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int st;

    ctrl_pipe #(.OP_W(4), .RA_W(4)) dut (
        .clk(clk), .rst(rst), .hold_i(hold_i),
        .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .stall_o(stall_o), .flush_o(flush_o),
        .ex_alu_op(ex_alu_op), .ex_alu_fn(ex_alu_fn),
        .ex_r(ex_r), .ex_i(ex_i), .ex_j(ex_j),
        .mem_wr(mem_wr), .mem_rd(mem_rd),
        .wb_we(wb_we), .wb_sel_mem(wb_sel_mem), .wb_rd(wb_rd)
`ifdef CTRL_FWD_EN
        , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                          input logic [3:0] rd);
        op_i = op; rs_i = rs; rt_i = rt; rd_i = rd;
    endtask

    // Front-end model: keep the instruction in ID while stalled, then let it enter EX.
    task automatic issue(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] rd, output int stalls);
        set_id(op, rs, rt, rd);
        stalls = 0;
        #1;
        while (stall_o && stalls < 8) begin
            stalls++;
            tick();
        end
        tick();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; hold_i = 1'b0;
        set_id(4'h0, 4'h0, 4'h0, 4'h0);
        tick(); tick();
        check("rst_stall", stall_o, 0);
        check("rst_flush", flush_o, 0);
        check("rst_wb_we", wb_we, 0);
        check("rst_alu_op", ex_alu_op, 2'b11);
        check("rst_mem", {mem_wr, mem_rd}, 0);
`ifdef CTRL_FWD_EN
        check("rst_fwd", {fwd_a, fwd_b}, 0);
`endif
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            tick();
            check("nop_alu_op", ex_alu_op, 2'b11);
            check("nop_wb_we", wb_we, 0);
            check("nop_stall", stall_o, 0);
        end

        // RAW: ADD r3 <- r1,r2 ; ADD r6 <- r3,r4
        issue(4'hC, 4'h1, 4'h2, 4'h3, st);
        check("add1_stalls", st, 0);
        check("add1_alu_op", ex_alu_op, 2'b01);
        check("add1_fn", ex_alu_fn, 4'hC);
        check("add1_r", {ex_r, ex_i, ex_j}, 3'b100);
        issue(4'hC, 4'h3, 4'h4, 4'h6, st);
        check("raw_stalls", st, RAW_ST);
        check("raw_fn", ex_alu_fn, 4'hC);
`ifdef CTRL_FWD_EN
        check("raw_fwd_a", fwd_a, 2'b01);
        check("raw_fwd_b", fwd_b, 2'b00);
`endif
        for (int k = 0; k < 3; k++) issue(4'h0, 4'h0, 4'h0, 4'h0, st);

        // Load-use: LOAD r5 <- [r2] ; SUB r7 <- r1,r5
        issue(4'h1, 4'h2, 4'h0, 4'h5, st);
        check("ld_alu_op", ex_alu_op, 2'b10);
        check("ld_class", {ex_r, ex_i, ex_j}, 3'b010);
        set_id(4'hD, 4'h1, 4'h5, 4'h7);
        #1;
        check("lu_stall", stall_o, 1);
        check("lu_flush", flush_o, 0);
        issue(4'hD, 4'h1, 4'h5, 4'h7, st);
        check("lu_stalls", st, LU_ST);
        check("lu_fn", ex_alu_fn, 4'hD);
        check("lu_mem_bubble", {mem_wr, mem_rd}, 0);
`ifdef CTRL_FWD_EN
        check("lu_fwd_b", fwd_b, 2'b10);
        check("lu_fwd_a", fwd_a, 2'b00);
        check("lu_wb", {wb_we, wb_sel_mem, wb_rd}, {2'b11, 4'h5});
`endif
        for (int k = 0; k < 3; k++) issue(4'h0, 4'h0, 4'h0, 4'h0, st);

        // Jump
        set_id(4'hF, 4'h0, 4'h0, 4'h0);
        #1;
        check("j_flush", flush_o, 1);
        check("j_stall", stall_o, 0);
        tick();
        set_id(4'h0, 4'h0, 4'h0, 4'h0);
        #1;
        check("j_alu_op", ex_alu_op, 2'b00);
        check("j_ex_j", ex_j, 1);
        check("j_flush_off", flush_o, 0);
        for (int k = 0; k < 3; k++) issue(4'h0, 4'h0, 4'h0, 4'h0, st);

        // Hold during a load-use hazard: LOAD r9 ; SUB r4 <- r9,r2
        issue(4'h1, 4'h0, 4'h0, 4'h9, st);
        set_id(4'hD, 4'h9, 4'h2, 4'h4);
        hold_i = 1'b1;
        #1;
        check("hold_stall", stall_o, 1);
        check("hold_flush", flush_o, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_alu_op", ex_alu_op, 2'b10);
            check("hold_fn", ex_alu_fn, 4'h1);
            check("hold_mem_rd", mem_rd, 0);
        end
        hold_i = 1'b0;
        #1;
        check("hold_lu_stall", stall_o, 1);
        issue(4'hD, 4'h9, 4'h2, 4'h4, st);
        check("hold_lu_stalls", st, LU_ST);
        check("hold_lu_fn", ex_alu_fn, 4'hD);
`ifdef CTRL_FWD_EN
        check("hold_fwd_a", fwd_a, 2'b10);
`endif
        for (int k = 0; k < 3; k++) issue(4'h0, 4'h0, 4'h0, 4'h0, st);

        // Hold beats jump flush
        set_id(4'hF, 4'h0, 4'h0, 4'h0);
        hold_i = 1'b1;
        #1;
        check("holdj_flush", flush_o, 0);
        check("holdj_stall", stall_o, 1);
        tick();
        check("holdj_alu_op", ex_alu_op, 2'b11);
        hold_i = 1'b0;
        #1;
        check("holdj_flush_rel", flush_o, 1);
        tick();
        check("holdj_ex_alu_op", ex_alu_op, 2'b00);
        for (int k = 0; k < 3; k++) issue(4'h0, 4'h0, 4'h0, 4'h0, st);

        // Reset during a load-use stall
        issue(4'h1, 4'h0, 4'h0, 4'h8, st);
        set_id(4'hC, 4'h8, 4'h1, 4'h2);
        #1;
        check("rst_pre_stall", stall_o, 1);
        rst = 1'b1;
        tick();
        check("rst_mid_stall", stall_o, 0);
        check("rst_mid_alu_op", ex_alu_op, 2'b11);
        check("rst_mid_mem", {mem_wr, mem_rd}, 0);
        check("rst_mid_wb", {wb_we, wb_sel_mem, wb_rd}, 0);
        rst = 1'b0;
        tick();
        check("post_rst_fn", ex_alu_fn, 4'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
